// File: rtl/ro_pair_compare.sv
// RO PUF pair comparator: drives the two mux selects, counts synchronized rising
// edges of both selected oscillators over a fixed window, and emits cnt_a > cnt_b.
module ro_pair_compare #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       challenge,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic [3:0]       sel_a,
  output logic [3:0]       sel_b,
  output logic             ro_en,
  output logic             busy,
  output logic             resp_valid,
  output logic             resp_bit,
  output logic             tie,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [1:0]       dbg_state
);

  localparam int PH_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t            state_q;
  logic [PH_W-1:0]   phase_q;
  logic [3:0]        sel_a_q, sel_b_q;
  logic              ro_en_q, busy_q, resp_valid_q, resp_bit_q, tie_q;
  logic [CNT_W-1:0]  cnt_a_q, cnt_b_q, cnt_a_d, cnt_b_d;
  logic              a_s1_q, a_s2_q, a_h_q;
  logic              b_s1_q, b_s2_q, b_h_q;
  logic              edge_a, edge_b;

  // Synchronizers and history flops run in every state so no stale edge is
  // seen when counting starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      {a_s1_q, a_s2_q, a_h_q} <= 3'b000;
      {b_s1_q, b_s2_q, b_h_q} <= 3'b000;
    end else begin
      a_s1_q <= ro_a;
      a_s2_q <= a_s1_q;
      a_h_q  <= a_s2_q;
      b_s1_q <= ro_b;
      b_s2_q <= b_s1_q;
      b_h_q  <= b_s2_q;
    end
  end

  assign edge_a = a_s2_q & ~a_h_q;
  assign edge_b = b_s2_q & ~b_h_q;

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (edge_a && (cnt_a_q != {CNT_W{1'b1}})) cnt_a_d = cnt_a_q + 1'b1;
    if (edge_b && (cnt_b_q != {CNT_W{1'b1}})) cnt_b_d = cnt_b_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      sel_a_q      <= 4'd0;
      sel_b_q      <= 4'd0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      ro_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_bit_q   <= 1'b0;
      tie_q        <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sel_a_q    <= challenge[7:4];
            sel_b_q    <= challenge[3:0];
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            phase_q    <= '0;
            resp_bit_q <= 1'b0;
            tie_q      <= 1'b0;
            ro_en_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SETTLE;
          end
        end
        SETTLE: begin
          if (phase_q == PH_W'(SETTLE_CYCLES - 1)) begin
            phase_q <= '0;
            state_q <= COUNT;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        COUNT: begin
          cnt_a_q <= cnt_a_d;
          cnt_b_q <= cnt_b_d;
          // The verdict uses the counts including this last window cycle.
          if (phase_q == PH_W'(WINDOW_CYCLES - 1)) begin
            phase_q      <= '0;
            ro_en_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_bit_q   <= (cnt_a_d > cnt_b_d);
            tie_q        <= (cnt_a_d == cnt_b_d);
            state_q      <= RESULT;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        RESULT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel_a      = sel_a_q;
  assign sel_b      = sel_b_q;
  assign ro_en      = ro_en_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_bit   = resp_bit_q;
  assign tie        = tie_q;
  assign cnt_a      = cnt_a_q;
  assign cnt_b      = cnt_b_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ro_pair_compare.sv
// Bench for ro_pair_compare: cycle-level reference model with per-cycle compare,
// plus directed scenarios with literal expectations.
module tb_ro_pair_compare;

  localparam int W = 100;
  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start_s;
  logic [7:0]  challenge, chal_s;
  logic        ro_a, ro_b;
  logic [3:0]  sel_a, sel_b, sel_a_s, sel_b_s;
  logic        ro_en, busy, resp_valid, resp_bit, tie;
  logic        ro_en_s, busy_s, resp_valid_s, resp_bit_s, tie_s;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_a_s, cnt_b_s;
  logic [1:0]  dbg_state, dbg_state_s;

  int errors = 0;
  int checks = 0;

  ro_pair_compare #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge),
    .ro_a(ro_a), .ro_b(ro_b), .sel_a(sel_a), .sel_b(sel_b),
    .ro_en(ro_en), .busy(busy), .resp_valid(resp_valid),
    .resp_bit(resp_bit), .tie(tie), .cnt_a(cnt_a), .cnt_b(cnt_b),
    .dbg_state(dbg_state)
  );

  ro_pair_compare #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .challenge(chal_s),
    .ro_a(ro_a), .ro_b(ro_b), .sel_a(sel_a_s), .sel_b(sel_b_s),
    .ro_en(ro_en_s), .busy(busy_s), .resp_valid(resp_valid_s),
    .resp_bit(resp_bit_s), .tie(tie_s), .cnt_a(cnt_a_s), .cnt_b(cnt_b_s),
    .dbg_state(dbg_state_s)
  );

  // Oscillators: edges land at 2/3 ns past a 10 ns boundary, never on a clk edge.
  int half_a = 20;
  int half_b = 30;
  initial begin
    ro_a = 1'b0;
    #2;
    forever begin
      ro_a = ~ro_a;
      #(half_a);
    end
  end
  initial begin
    ro_b = 1'b0;
    #3;
    forever begin
      ro_b = ~ro_b;
      #(half_b);
    end
  end

  int ra_cnt = 0;
  int rb_cnt = 0;
  always @(posedge ro_a) ra_cnt++;
  always @(posedge ro_b) rb_cnt++;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input longint got, input longint lo, input longint hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, got, lo, hi, $time);
    end
  endtask

  // Reference model: m_t counts clock edges since the accepted start edge.
  bit         m_ok = 1'b0;
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [3:0] m_sel_a = 4'd0, m_sel_b = 4'd0;
  int         m_mode = 0;  // 0: counts must be zero, 1: counting, 2: result known
  int         snap_a = 0, snap_b = 0, m_ca = 0, m_cb = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1;
      m_active = 1'b0;
      m_t = 0;
      m_sel_a = 4'd0;
      m_sel_b = 4'd0;
      m_mode = 0;
    end else if (m_ok) begin
      if (m_active) begin
        m_t++;
        if (m_t == S) begin
          snap_a = ra_cnt;
          snap_b = rb_cnt;
          m_mode = 1;
        end
        if (m_t == S + W) begin
          m_ca = ra_cnt - snap_a;
          m_cb = rb_cnt - snap_b;
          m_mode = 2;
        end
        if (m_t == S + W + 1) m_active = 1'b0;
      end else if (start) begin
        m_active = 1'b1;
        m_t = 0;
        m_sel_a = challenge[7:4];
        m_sel_b = challenge[3:0];
        m_mode = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_busy", busy, m_active);
      chk("m_ro_en", ro_en, m_active && (m_t < S + W));
      chk("m_resp_valid", resp_valid, m_active && (m_t == S + W));
      chk("m_sel_a", sel_a, m_sel_a);
      chk("m_sel_b", sel_b, m_sel_b);
      if (m_mode == 0) begin
        chk("m_cnt_a_zero", cnt_a, 0);
        chk("m_cnt_b_zero", cnt_b, 0);
        chk("m_resp_bit_zero", resp_bit, 0);
        chk("m_tie_zero", tie, 0);
      end else if (m_mode == 2) begin
        chk_rng("m_cnt_a", cnt_a, m_ca - 1, m_ca + 1);
        chk_rng("m_cnt_b", cnt_b, m_cb - 1, m_cb + 1);
        if (m_ca > m_cb + 2) begin
          chk("m_resp_bit", resp_bit, 1);
          chk("m_tie", tie, 0);
        end else if (m_cb > m_ca + 2) begin
          chk("m_resp_bit", resp_bit, 0);
          chk("m_tie", tie, 0);
        end
      end
    end
  end

  // One evaluation on the main instance; returns at the negedge showing resp_valid.
  task automatic run_eval(input logic [7:0] c, input int sa, input int sb,
                          input int alo, input int ahi, input int blo, input int bhi,
                          input int exp_bit, input string name);
    int n;
    bit found;
    @(negedge clk);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_idle_rv"}, resp_valid, 0);
    start = 1'b1;
    challenge = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({name, "_busy"}, busy, 1);
    chk({name, "_ro_en"}, ro_en, 1);
    chk({name, "_sel_a"}, sel_a, sa);
    chk({name, "_sel_b"}, sel_b, sb);
    n = 0;
    found = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        n = i;
        found = 1'b1;
        break;
      end
    end
    chk({name, "_rv_seen"}, found, 1);
    chk({name, "_latency"}, n, 105);
    chk_rng({name, "_cnt_a"}, cnt_a, alo, ahi);
    chk_rng({name, "_cnt_b"}, cnt_b, blo, bhi);
    chk({name, "_resp_bit"}, resp_bit, exp_bit);
    chk({name, "_tie"}, tie, 0);
  endtask

  initial begin
    int pulses;
    int n;
    bit found;
    rst = 1'b1;
    start = 1'b0;
    challenge = 8'h00;
    start_s = 1'b0;
    chal_s = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ro_en", ro_en, 0);
    chk("rst_rv", resp_valid, 0);
    chk("rst_sel_a", sel_a, 0);
    chk("rst_sel_b", sel_b, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    chk("rst_resp_bit", resp_bit, 0);
    chk("rst_tie", tie, 0);
    chk("rst_sat_busy", busy_s, 0);

    run_eval(8'h3A, 3, 10, 24, 26, 16, 18, 1, "a_fast");
    half_a = 30;
    half_b = 20;
    run_eval(8'h3A, 3, 10, 16, 18, 24, 26, 0, "b_fast");
    run_eval(8'h3A, 3, 10, 16, 18, 24, 26, 0, "b_fast_rep");

    // Saturation and tie on the 4-bit instance, both oscillators at 40 ns.
    half_a = 20;
    repeat (10) @(negedge clk);
    start_s = 1'b1;
    chal_s = 8'h21;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    n = 0;
    found = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (resp_valid_s) begin
        n = i;
        found = 1'b1;
        break;
      end
    end
    chk("sat_rv_seen", found, 1);
    chk("sat_latency", n, 105);
    chk("sat_cnt_a", cnt_a_s, 15);
    chk("sat_cnt_b", cnt_b_s, 15);
    chk("sat_tie", tie_s, 1);
    chk("sat_resp_bit", resp_bit_s, 0);
    chk("sat_sel_a", sel_a_s, 2);

    // Starts during SETTLE and COUNT must be dropped.
    @(negedge clk);
    start = 1'b1;
    challenge = 8'h5C;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    challenge = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    chk("ign_settle_sel_a", sel_a, 5);
    chk("ign_settle_sel_b", sel_b, 12);
    repeat (50) @(negedge clk);
    start = 1'b1;
    challenge = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    chk("ign_count_sel_a", sel_a, 5);
    chk("ign_count_sel_b", sel_b, 12);
    chk("ign_count_busy", busy, 1);
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_end_busy", busy, 0);
    chk("ign_end_sel_a", sel_a, 5);

    // Reset in the middle of COUNT aborts without a response.
    @(negedge clk);
    start = 1'b1;
    challenge = 8'h3A;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (S + 50) @(negedge clk);
    chk("abort_pre_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ro_en", ro_en, 0);
    chk("abort_cnt_a", cnt_a, 0);
    chk("abort_cnt_b", cnt_b, 0);
    chk("abort_sel_a", sel_a, 0);
    chk("abort_rv", resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    chk("abort_no_rv", pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
